// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Self-test sequencer for the 3-input GATE block. On start it
//               walks the eight input vectors 0..7 in order. Each vector is
//               held for SETTLE_CYC cycles, then the seven GATE outputs are
//               compared against an internal golden model. The block reports
//               a pass flag, an error count and the first failing vector and
//               mask.
// Ports       :
//   clk              in   1  clock, rising edge
//   rst              in   1  synchronous active-high reset
//   start            in   1  begin a sweep (sampled only when idle)
//   abort            in   1  cancel a running sweep
//   obs              in   7  GATE outputs {EXOR,BUF,NOT,NOR,NAND,OR,AND}
//   in_1/in_2/in_3   out  1  registered GATE inputs (vector bits 0/1/2)
//   busy             out  1  high whenever a sweep is in progress
//   done             out  1  one-cycle pulse at sweep completion
//   pass             out  1  last completed sweep had zero errors (held)
//   err_cnt          out  4  failing vectors in current/last sweep, 0..8
//   first_fail_vec   out  3  vector index of the first mismatch
//   first_fail_mask  out  7  obs XOR expected at the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] obs,
  output logic       in_1,
  output logic       in_2,
  output logic       in_3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail_vec,
  output logic [6:0] first_fail_mask
);

  // --------------------------------------------------------------------------
  // Parameter legality: the settle counter is 8 bits and must run at least once
  // --------------------------------------------------------------------------
  generate
    if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_param_check
      $error("gate_sweep_ctrl: SETTLE_CYC must be in 1..255");
    end
  endgenerate

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_drive  = 3'd1;
  localparam logic [2:0] c_st_settle = 3'd2;
  localparam logic [2:0] c_st_check  = 3'd3;
  localparam logic [2:0] c_st_finish = 3'd4;

  // Counter is loaded with SETTLE_CYC-1 and SETTLE exits when it reads zero,
  // which gives exactly SETTLE_CYC cycles in SETTLE.
  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] c_err_max     = 4'd8;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [2:0] r_vec;
  logic [7:0] r_settle_cnt;
  logic [2:0] r_in;
  logic       r_pass;
  logic [3:0] r_err_cnt;
  logic [2:0] r_ff_vec;
  logic [6:0] r_ff_mask;

  logic [6:0] w_expected;
  logic [6:0] w_diff;
  logic       w_mismatch;
  logic       w_abort_run;

  // --------------------------------------------------------------------------
  // Golden GATE model for the vector currently under test
  // --------------------------------------------------------------------------
  always_comb begin
    w_expected    = '0;
    w_expected[0] = &r_vec;          // AND
    w_expected[1] = |r_vec;          // OR
    w_expected[2] = ~(&r_vec);       // NAND
    w_expected[3] = ~(|r_vec);       // NOR
    w_expected[4] = ~r_vec[0];       // NOT of in_1
    w_expected[5] = r_vec[0];        // BUF of in_1
    w_expected[6] = ^r_vec;          // EXOR, odd parity
  end

  assign w_diff      = obs ^ w_expected;
  assign w_mismatch  = (w_diff != 7'd0);
  assign w_abort_run = abort && (r_state != c_st_idle);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Abort overrides every non-idle transition.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (start && !abort) begin
          w_state_next = c_st_drive;
        end
      end
      c_st_drive: begin
        w_state_next = c_st_settle;
      end
      c_st_settle: begin
        if (r_settle_cnt == 8'd0) begin
          w_state_next = c_st_check;
        end
      end
      c_st_check: begin
        if (r_vec == 3'd7) begin
          w_state_next = c_st_finish;
        end else begin
          w_state_next = c_st_drive;
        end
      end
      c_st_finish: begin
        w_state_next = c_st_idle;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
    if (w_abort_run) begin
      w_state_next = c_st_idle;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_finish);
  end

  // --------------------------------------------------------------------------
  // Datapath: vector index, settle counter, GATE drive, result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec        <= '0;
      r_settle_cnt <= '0;
      r_in         <= '0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_ff_vec     <= '0;
      r_ff_mask    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_in <= '0;
          if (start && !abort) begin
            r_vec     <= '0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_ff_vec  <= '0;
            r_ff_mask <= '0;
          end
        end
        c_st_drive: begin
          r_in         <= r_vec;
          r_settle_cnt <= c_settle_last;
        end
        c_st_settle: begin
          if (r_settle_cnt != 8'd0) begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
          end
        end
        c_st_check: begin
          // A compare coinciding with abort is discarded entirely.
          if (!abort) begin
            if (w_mismatch && (r_err_cnt != c_err_max)) begin
              r_err_cnt <= r_err_cnt + 4'd1;
            end
            // Zero errors so far means this mismatch is the first one.
            if (w_mismatch && (r_err_cnt == 4'd0)) begin
              r_ff_vec  <= r_vec;
              r_ff_mask <= w_diff;
            end
            // Pass is resolved here so it is already valid while done pulses.
            if (r_vec == 3'd7) begin
              r_pass <= (r_err_cnt == 4'd0) && !w_mismatch;
            end else begin
              r_vec <= r_vec + 3'd1;
            end
          end
        end
        c_st_finish: begin
          r_in <= '0;
        end
        default: begin
          r_in <= '0;
        end
      endcase
      // Leaving a sweep early: park the GATE inputs and report no pass.
      // Partial error count and first-fail capture are deliberately kept.
      if (w_abort_run) begin
        r_in   <= '0;
        r_pass <= 1'b0;
      end
    end
  end

  assign in_1            = r_in[0];
  assign in_2            = r_in[1];
  assign in_3            = r_in[2];
  assign pass            = r_pass;
  assign err_cnt         = r_err_cnt;
  assign first_fail_vec  = r_ff_vec;
  assign first_fail_mask = r_ff_mask;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Bench for gate_sweep_ctrl. A configurable GATE model (ideal,
//               EXOR stuck-at-0, random per-vector corruption, glitchy while
//               settling) drives obs. Expected sweep results come from a
//               vector-level reference model; expected timing comes from the
//               per-vector cycle schedule counted from the start cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

  localparam int S      = 4;
  localparam int PER    = S + 2;
  localparam int DONE_N = 8 * PER + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] obs;
  logic       in_1, in_2, in_3, busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] ffv;
  logic [6:0] ffm;

  int n_vec = 0;
  int n_err = 0;
  int last_e = 0;

  int         mode = 0;          // 0 ideal, 1 EXOR stuck 0, 2 random xor masks
  logic [6:0] xmask [8];
  logic       noise_en = 1'b0;
  logic [6:0] noise_mask = 7'd1;
  wire  [2:0] vin = {in_3, in_2, in_1};

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .obs(obs),
    .in_1(in_1), .in_2(in_2), .in_3(in_3), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_fail_vec(ffv),
    .first_fail_mask(ffm)
  );

  function automatic logic [6:0] golden(input logic [2:0] v);
    logic a, b, c;
    a = v[0]; b = v[1]; c = v[2];
    return {a ^ b ^ c, a, ~a, ~(a | b | c), ~(a & b & c), a | b | c, a & b & c};
  endfunction

  function automatic logic [6:0] gate_out(input logic [2:0] v, input int md,
                                          input logic [6:0] xm);
    case (md)
      1:       return golden(v) & 7'h3F;
      2:       return golden(v) ^ xm;
      default: return golden(v);
    endcase
  endfunction

  assign obs = noise_en ? (golden(vin) ^ noise_mask) : gate_out(vin, mode, xmask[vin]);

  // Vector presented on in_x during cycle n of a sweep (cycle 0 = start cycle)
  function automatic int exp_in(input int n);
    if (n <= 1 || n > DONE_N) return 0;
    if (n == DONE_N) return 7;
    return (n - 2) / PER;
  endfunction

  // Reference result over the first nvec vectors of the sweep
  task automatic model(input int nvec, output int e, output logic [2:0] fv,
                       output logic [6:0] fm);
    logic [6:0] m;
    e = 0; fv = '0; fm = '0;
    for (int k = 0; k < nvec; k++) begin
      m = gate_out(3'(k), mode, xmask[k]) ^ golden(3'(k));
      if (m != 7'd0) begin
        if (e == 0) begin
          fv = 3'(k);
          fm = m;
        end
        e++;
      end
    end
  endtask

  task automatic randomize_masks();
    for (int k = 0; k < 8; k++)
      xmask[k] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
  endtask

  // One sweep. abort_n / rst_n / restart_n: cycle index at which that input is
  // pulsed (0 = never). stop_at_done ends the task on the done cycle.
  task automatic sweep(input int abort_n, input int rst_n, input int restart_n,
                       input bit noisy, input bit stop_at_done, input string tag);
    int term, last, e, nchk;
    logic [2:0] fv;
    logic [6:0] fm;
    logic exp_busy, exp_done, exp_pass;
    int exp_v;
    term = 0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s idle_busy got %b want 0", tag, busy);
    end
    start = 1'b1; abort = 1'b0;
    last = stop_at_done ? DONE_N : DONE_N + 2;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (term == 0 || n <= term) begin
        exp_busy = (n <= DONE_N); exp_done = (n == DONE_N); exp_v = exp_in(n);
      end else begin
        exp_busy = 1'b0; exp_done = 1'b0; exp_v = 0;
      end
      n_vec++;
      if (busy !== exp_busy || done !== exp_done || vin !== 3'(exp_v)) begin
        n_err++;
        $display("FAIL %s cycle%0d busy/done/in got %b/%b/%0d want %b/%b/%0d",
                 tag, n, busy, done, vin, exp_busy, exp_done, exp_v);
      end
      start      = (n == restart_n);
      abort      = (n == abort_n);
      rst        = (n == rst_n);
      noise_en   = noisy && (n % PER != 0);
      noise_mask = 7'($urandom_range(1, 127));
      if (n == abort_n || n == rst_n) term = n;
      if (term != 0 && n == term + 2) break;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; noise_en = 1'b0;
    if (rst_n != 0) begin
      e = 0; fv = '0; fm = '0; exp_pass = 1'b0;
    end else if (abort_n != 0) begin
      nchk = (abort_n - 1) / PER;
      if (nchk > 8) nchk = 8;
      model(nchk, e, fv, fm);
      exp_pass = 1'b0;
    end else begin
      model(8, e, fv, fm);
      exp_pass = (e == 0);
    end
    last_e = e;
    n_vec++;
    if (err_cnt !== 4'(e) || ffv !== fv || ffm !== fm || pass !== exp_pass) begin
      n_err++;
      $display("FAIL %s result err/vec/mask/pass got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
               tag, err_cnt, ffv, ffm, pass, e, fv, fm, exp_pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({vin, busy, done, pass, err_cnt, ffv, ffm} !== 20'd0) begin
      n_err++;
      $display("FAIL reset outputs got %h want 0",
               {vin, busy, done, pass, err_cnt, ffv, ffm});
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    mode = 0;
    sweep(0, 0, 0, 1'b0, 1'b0, "ideal");
  endtask

  task automatic test_exor_stuck();
    mode = 1;
    sweep(0, 0, 0, 1'b0, 1'b0, "exor_stuck");
    n_vec++;
    if (err_cnt !== 4'd4 || ffv !== 3'd1 || ffm !== 7'b1000000) begin
      n_err++;
      $display("FAIL exor_stuck fixed got %0d/%0d/%b want 4/1/1000000", err_cnt, ffv, ffm);
    end
  endtask

  // abort alone, then abort with start, while idle: nothing may change
  task automatic test_abort_idle();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || err_cnt !== 4'(last_e)) begin
        n_err++;
        $display("FAIL abort_idle busy/err got %b/%0d want 0/%0d", busy, err_cnt, last_e);
      end
    end
  endtask

  task automatic test_abort_settle();
    mode = 2; randomize_masks();
    sweep(3 * PER + 2 + $urandom_range(0, S - 1), 0, 0, 1'b0, 1'b0, "abort_settle");
  endtask

  task automatic test_abort_check();
    mode = 2; randomize_masks();
    sweep(PER * $urandom_range(1, 8), 0, 0, 1'b0, 1'b0, "abort_check");
  endtask

  task automatic test_restart_busy();
    mode = 2; randomize_masks();
    sweep(0, 0, $urandom_range(1, DONE_N - 1), 1'b0, 1'b0, "restart_busy");
  endtask

  task automatic test_back_to_back();
    mode = 1;
    sweep(0, 0, 0, 1'b0, 1'b1, "b2b_first");
    mode = 0;
    sweep(0, 0, 0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_rst_mid();
    mode = 2; randomize_masks();
    sweep(0, 5 * PER + $urandom_range(1, PER), 0, 1'b0, 1'b0, "rst_mid");
    mode = 0;
    sweep(0, 0, 0, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_settle_noise();
    mode = 0;
    sweep(0, 0, 0, 1'b1, 1'b0, "settle_noise");
  endtask

  task automatic test_random();
    int a;
    for (int i = 0; i < 6; i++) begin
      mode = 2; randomize_masks();
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DONE_N - 1) : 0;
      sweep(a, 0, 0, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) xmask[k] = 7'd0;
    test_reset();
    test_ideal();
    test_exor_stuck();
    test_abort_idle();
    test_abort_settle();
    test_abort_check();
    test_restart_busy();
    test_back_to_back();
    test_rst_mid();
    test_settle_noise();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
